// File: rtl/conv_ctrl.sv
// Frame sequencer for the convolutional codec: latches the code configuration on start,
// meters information bits plus zero tail into the encoder, or symbols into ACS followed by traceback.
module conv_ctrl #(
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int FRAME_LEN_W           = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_mode_sel,
  input  logic                   i_code_rate,
  input  logic [1:0]             i_constr_len,
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  input  logic                   i_bit_valid,
  input  logic                   i_bit,
  output logic                   o_bit_ready,
  input  logic                   i_sym_valid,
  output logic                   o_sym_ready,
  output logic                   o_en_c,
  output logic                   o_encoder_bit,
  output logic                   o_en_d,
  output logic                   o_tb_start,
  input  logic                   i_tb_done,
  output logic                   o_code_rate,
  output logic [1:0]             o_constr_len,
  output logic                   o_mode_sel,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int   CNT_W     = FRAME_LEN_W + 1;
  localparam int   TAIL_W    = $clog2(MAX_CONSTRAINT_LENGTH);
  localparam logic RATE13_OK = 1'(MAX_CODE_RATE >= 3);

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_DATA, S_ENC_TAIL, S_DEC_ACS, S_DEC_TB, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FRAME_LEN_W-1:0] frameLen_q;
  logic                   codeRate_q, modeSel_q;
  logic [1:0]             constrLen_q;
  logic                   latchCfg;
  logic                   enC_q, enC_d, encBit_q, encBit_d, enD_q, enD_d;
  logic                   tbStart_q, tbStart_d, tbIssued_q, tbIssued_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [TAIL_W-1:0]      tailLen;
  logic [CNT_W-1:0]       cntInc, decTarget;

  // Tail length K-1 = 2*(constr_len+1): 2, 4, 6 or 8 zero bits.
  assign tailLen   = TAIL_W'({constrLen_q, 1'b0}) + TAIL_W'(2);
  assign cntInc    = count_q + CNT_W'(1);
  assign decTarget = CNT_W'(frameLen_q) + CNT_W'(tailLen);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    latchCfg    = 1'b0;
    enC_d       = 1'b0;
    encBit_d    = 1'b0;
    enD_d       = 1'b0;
    tbStart_d   = 1'b0;
    tbIssued_d  = tbIssued_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    o_bit_ready = 1'b0;
    o_sym_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        tbIssued_d = 1'b0;
        if (i_start) begin
          if (i_frame_len != '0) begin
            latchCfg = 1'b1;
            count_d  = '0;
            state_d  = i_mode_sel ? S_DEC_ACS : S_ENC_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ENC_DATA: begin
        o_bit_ready = 1'b1;
        if (i_bit_valid) begin
          enC_d    = 1'b1;
          encBit_d = i_bit;
          if (cntInc == CNT_W'(frameLen_q)) begin
            count_d = '0;
            state_d = S_ENC_TAIL;
          end else begin
            count_d = cntInc;
          end
        end
      end
      S_ENC_TAIL: begin
        enC_d = 1'b1;
        if (cntInc == CNT_W'(tailLen)) begin
          count_d = '0;
          state_d = S_DONE;
        end else begin
          count_d = cntInc;
        end
      end
      S_DEC_ACS: begin
        o_sym_ready = 1'b1;
        if (i_sym_valid) begin
          enD_d = 1'b1;
          if (cntInc == decTarget) begin
            count_d = '0;
            state_d = S_DEC_TB;
          end else begin
            count_d = cntInc;
          end
        end
      end
      // The launch cycle is spent issuing tb_start, so tb_done counts only afterwards.
      S_DEC_TB: begin
        if (!tbIssued_q) begin
          tbStart_d  = 1'b1;
          tbIssued_d = 1'b1;
        end else if (i_tb_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      frameLen_q  <= '0;
      codeRate_q  <= 1'b0;
      modeSel_q   <= 1'b0;
      constrLen_q <= 2'b00;
      enC_q       <= 1'b0;
      encBit_q    <= 1'b0;
      enD_q       <= 1'b0;
      tbStart_q   <= 1'b0;
      tbIssued_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      enC_q      <= enC_d;
      encBit_q   <= encBit_d;
      enD_q      <= enD_d;
      tbStart_q  <= tbStart_d;
      tbIssued_q <= tbIssued_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (latchCfg) begin
        frameLen_q  <= i_frame_len;
        codeRate_q  <= i_code_rate & RATE13_OK;
        modeSel_q   <= i_mode_sel;
        constrLen_q <= i_constr_len;
      end
    end
  end

  assign o_en_c        = enC_q;
  assign o_encoder_bit = encBit_q;
  assign o_en_d        = enD_q;
  assign o_tb_start    = tbStart_q;
  assign o_code_rate   = codeRate_q;
  assign o_constr_len  = constrLen_q;
  assign o_mode_sel    = modeSel_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
